// File: rtl/md_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   - md_state_e : IDLE / CALC / FIX sequencing states
//   - MD_MULT/MD_DIV : md_sel encodings
//   - MD_WIDTH/MD_ITERS : operand width and iteration count
//   - abs/negate helpers for two's-complement magnitude handling
package md_pkg;

  localparam int   MD_WIDTH = 32;
  localparam int   MD_ITERS = 32;
  localparam logic MD_MULT  = 1'b0;
  localparam logic MD_DIV   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Two's-complement negate, modulo 2^32.
  function automatic logic [MD_WIDTH-1:0] neg32(input logic [MD_WIDTH-1:0] v);
    return ~v + 32'd1;
  endfunction

  // Two's-complement negate, modulo 2^64.
  function automatic logic [2*MD_WIDTH-1:0] neg64(input logic [2*MD_WIDTH-1:0] v);
    return ~v + 64'd1;
  endfunction

  // Unsigned magnitude; |-2^31| comes out as 0x80000000.
  function automatic logic [MD_WIDTH-1:0] abs32(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 multiplier / divider for the HI/LO registers.
// A start pulse in IDLE loads operand magnitudes, 32 shift-add (MULT) or
// restoring (DIV) iterations follow, then one FIX cycle restores signs and
// registers the result. done pulses one cycle with hi/lo valid.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : launch request, honoured only in IDLE
//   md_sel       : 0 = MULT, 1 = DIV
//   a, b         : signed operands (multiplicand/dividend, multiplier/divisor)
//   hi, lo       : MULT product[63:32]/[31:0]; DIV remainder/quotient
//   busy         : operation in progress
//   done         : one-cycle completion pulse
//   div0         : combinational b == 0
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             md_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  md_state_e         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [WIDTH:0]    acc_q, acc_d;      // MULT: upper product half; DIV: remainder
  logic [WIDTH-1:0]  sr_q, sr_d;        // MULT: multiplier/low product; DIV: dividend/quotient
  logic [WIDTH-1:0]  mcand_q, mcand_d;  // MULT: |a|; DIV: |b|
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;

  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     add_a_s;
  logic [WIDTH:0]     add_b_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quot_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  assign div0 = (b == 32'd0);
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Shared 33-bit adder: MULT adds the multiplicand when the multiplier LSB
  // is set; DIV subtracts the divisor (invert + carry-in) from the shifted
  // remainder. Also forms the sign-corrected results used in FIX.
  always_comb begin
    rem_sh_s = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
    if (op_q == MD_DIV) begin
      add_a_s = rem_sh_s;
      add_b_s = ~{1'b0, mcand_q};
    end else begin
      add_a_s = acc_q;
      add_b_s = sr_q[0] ? {1'b0, mcand_q} : 33'd0;
    end
    sum_s = add_a_s + add_b_s + {32'd0, op_q};

    prod_fix_s = {acc_q[WIDTH-1:0], sr_q};
    if (sign_a_q ^ sign_b_q) begin
      prod_fix_s = neg64(prod_fix_s);
      quot_fix_s = neg32(sr_q);
    end else begin
      quot_fix_s = sr_q;
    end
    if (sign_a_q) begin
      rem_fix_s = neg32(acc_q[WIDTH-1:0]);
    end else begin
      rem_fix_s = acc_q[WIDTH-1:0];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sr_d     = sr_q;
    mcand_d  = mcand_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // A DIV by zero is refused here; the control unit handles it via div0.
        if (start && !((md_sel == MD_DIV) && div0)) begin
          state_d  = CALC;
          cnt_d    = 5'd0;
          acc_d    = 33'd0;
          op_d     = md_sel;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          if (md_sel == MD_DIV) begin
            mcand_d = abs32(b);
            sr_d    = abs32(a);
          end else begin
            mcand_d = abs32(a);
            sr_d    = abs32(b);
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (op_q == MD_DIV) begin
          // Non-negative trial result (bit 32 clear) means the subtract fits.
          if (!sum_s[WIDTH]) begin
            acc_d = sum_s;
            sr_d  = {sr_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh_s;
            sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, sum_s[WIDTH:1]};
          sr_d  = {sum_s[0], sr_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MD_ITERS - 1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end

      FIX: begin
        if (op_q == MD_DIV) begin
          hi_d = rem_fix_s;
          lo_d = quot_fix_s;
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 33'd0;
      sr_q     <= 32'd0;
      mcand_q  <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      op_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sr_q     <= sr_d;
      mcand_q  <= mcand_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        md_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_sel(md_sel),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a start pulse for one edge; returns at the negedge after E0.
  task automatic launch(input logic sel, input logic [31:0] av, input logic [31:0] bv);
    md_sel = sel;
    a      = av;
    b      = bv;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for done; lat0 is the number of edges already past E0.
  task automatic finish_op(input int lat0, input logic [31:0] eh, input logic [31:0] el,
                           input string nm);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " busy"}, {63'd0, busy}, 64'd0);
    chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{1'b0, 32'd3,          32'd4,        32'h00000000, 32'h0000000C};
    vecs[5]  = '{1'b1, 32'd100,        32'd7,        32'h00000002, 32'h0000000E};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[9]  = '{1'b0, 32'h12345678,   32'h00000010, 32'h00000001, 32'h23456780};
    vecs[10] = '{1'b1, 32'd5,          32'd10,       32'h00000005, 32'h00000000};
    vecs[11] = '{1'b0, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[12] = '{1'b1, 32'h80000000,   32'd1,        32'h00000000, 32'h80000000};
    vecs[13] = '{1'b0, 32'd5,          32'd0,        32'h00000000, 32'h00000000};
    vecs[14] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};

    reset  = 1'b1;
    start  = 1'b0;
    md_sel = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset hi",   {32'd0, hi}, 64'd0);
    chk("reset lo",   {32'd0, lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset div0", {63'd0, div0}, 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].sel, vecs[i].av, vecs[i].bv);
      finish_op(0, vecs[i].ehi, vecs[i].elo, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Divide by zero is refused; hi/lo keep the last result (vec14).
    md_sel = 1'b1;
    a      = 32'd9;
    b      = 32'd0;
    start  = 1'b1;
    #1;
    chk("div0 flag", {63'd0, div0}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk("div0 busy", {63'd0, busy}, 64'd0);
      chk("div0 done", {63'd0, done}, 64'd0);
      @(negedge clk);
    end
    chk("div0 hi held", {32'd0, hi}, 64'h00000000FFFFFFFE);
    chk("div0 lo held", {32'd0, lo}, 64'h000000000000000E);
    b = 32'd3;
    #1;
    chk("div0 clear", {63'd0, div0}, 64'd0);

    // Start while busy is ignored; start in the done cycle launches again.
    @(negedge clk);
    launch(MD_MULT, 32'd7, 32'hFFFFFFFD);
    repeat (9) @(negedge clk);
    md_sel = MD_DIV;
    a      = 32'd3;
    b      = 32'd4;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    finish_op(10, 32'hFFFFFFFF, 32'hFFFFFFEB, "restart ignored");
    launch(MD_DIV, 32'd100, 32'd7);
    finish_op(0, 32'h00000002, 32'h0000000E, "back to back");

    // Reset mid-DIV aborts immediately.
    @(negedge clk);
    launch(MD_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort hi",   {32'd0, hi}, 64'd0);
    chk("abort lo",   {32'd0, lo}, 64'd0);
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk("abort no done", {63'd0, done}, 64'd0);
      @(negedge clk);
    end
    launch(MD_MULT, 32'd3, 32'd4);
    finish_op(0, 32'h00000000, 32'h0000000C, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
